pipelined_dual_port_memory_subsystem: RTL and testbench
=======================================================

Name: pipelined_dual_port_memory_subsystem

Overview:
Parametrised successor to the single-cycle dual-port BRAM memory subsystem. It serves an instruction-fetch port (read-only) and a data port (read/write with byte enables) from one shared word array. Adds over the previous generation:
- configurable read latency
- wait-state backpressure through real ready signals
- out-of-range address detection with an error flag
- defined same-word collision behaviour

It sits between the core's fetch/memory stages and on-chip RAM.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8.
ADDRESS_BITS, 32, width of the byte address from the core.
MEM_ADDRESS_BITS, 12, byte-address bits decoded by the memory; depth = 2^MEM_ADDRESS_BITS / (DATA_WIDTH/8) words.
READ_LATENCY, 1, cycles from request acceptance to valid; legal range 1..4.
WAIT_STATES, 0, extra busy cycles a port inserts after each accepted request; legal range 0..7.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
i_mem_read  in  1  fetch request
i_mem_address_in  in  ADDRESS_BITS  fetch byte address
i_mem_data_out  out  DATA_WIDTH  fetched word
i_mem_address_out  out  ADDRESS_BITS  address of the returned word
i_mem_valid  out  1  one-cycle pulse, i_mem_data_out valid
i_mem_ready  out  1  fetch port can accept a request
i_mem_error  out  1  returned fetch was out of range; aligned with valid
d_mem_read  in  1  data read request
d_mem_write  in  1  data write request
d_mem_byte_en  in  DATA_WIDTH/8  write byte lanes
d_mem_address_in  in  ADDRESS_BITS  data byte address
d_mem_data_in  in  DATA_WIDTH  write data
d_mem_data_out  out  DATA_WIDTH  read data
d_mem_address_out  out  ADDRESS_BITS  address of the returned read
d_mem_valid  out  1  one-cycle pulse, d_mem_data_out valid
d_mem_ready  out  1  data port can accept a request
d_mem_error  out  1  returned access was out of range; aligned with valid

Behaviour:
Acceptance and backpressure
- A request is accepted on a rising edge when (read|write) && ready. Requests presented while ready is low are ignored; the requester must hold them.
- Each port has a wait counter, 0..WAIT_STATES. On accept it loads WAIT_STATES, then decrements to 0. ready = (counter == 0).
- WAIT_STATES = 0 means ready is held at 1, which gives back-to-back acceptance.

Read pipeline
- The word index is address[MEM_ADDRESS_BITS-1 : log2(DATA_WIDTH/8)]; low byte-offset bits are ignored.
- An accepted read produces valid exactly READ_LATENCY cycles later as a 1-cycle pulse. data_out and address_out (the accepted address) are presented in that same cycle.
- Up to READ_LATENCY reads are in flight per port. Results return in order, one per cycle.
- data_out holds its last value while valid is low.

Writes (data port only)
- Only lanes with d_mem_byte_en[k]=1 are updated. A write with byte_en = 0 is accepted and changes nothing.
- Writes produce no valid pulse.
- Read and write asserted together: both act on the same word and the read returns the pre-write data (read-first).

Collisions
- Fetch read and data write to the same word in the same cycle: the fetch returns the old data. A fetch accepted the following cycle returns the new data.

Out-of-range
- Any of address[ADDRESS_BITS-1:MEM_ADDRESS_BITS] nonzero makes the access out of range.
- Out-of-range writes are suppressed.
- Out-of-range reads return data 0 with error=1 in the valid cycle.
- In-range reads return error=0.

Reset (reset=0, asynchronous)
- valid=0, error=0, address_out=0, data_out=0.
- Wait counters are cleared, so ready=1 from the first cycle after deassertion.
- The pipeline is flushed: reads in flight when reset asserts never produce valid.
- Memory contents are preserved.

Decomposition:
Shared package (mem_subsystem_pkg):
- log2 function
- NUM_BYTES = DATA_WIDTH/8
- WORD_ADDR_BITS = MEM_ADDRESS_BITS - log2(NUM_BYTES)
- bounds checks on READ_LATENCY and WAIT_STATES

Sub-module: mem_port_pipeline, instantiated once per port. It holds the wait counter, ready generation, range check, and the valid/address/error shift register of depth READ_LATENCY.

The top level owns the inferred true-dual-port byte-enabled word array (read-first) plus the data-path latency registers.

Test Plan:
1. READ_LATENCY=1, WAIT_STATES=0: write 0xDEADBEEF to 0x10 with byte_en=1111, then read 0x10 on both ports in the same cycle -> both valid after 1 cycle, data 0xDEADBEEF, address_out=0x10.
2. Byte lanes: write 0x000000AA to 0x20 with byte_en=0001 over existing 0x11223344; read back -> 0x112233AA. A write with byte_en=0000 leaves the word unchanged.
3. READ_LATENCY=3, WAIT_STATES=0: fetch reads to 0x0, 0x4, 0x8 on consecutive cycles -> valid on cycles +3, +4, +5 with matching address_out, in order.
4. WAIT_STATES=2: hold d_mem_read for 0x40 and 0x44 -> ready low for 2 cycles after the first accept; the second request is accepted on cycle 3; exactly two valid pulses.
5. Collision: same cycle, fetch read of 0x30 (old 0x1) and data write of 0x2 to 0x30 -> fetch returns 0x1; a fetch of 0x30 the next cycle returns 0x2. d-port read+write of 0x30 together returns the pre-write value.
6. Write to 0x0000_1000 (MEM_ADDRESS_BITS=12) -> array unchanged. Read 0x0000_1000 -> data 0, d_mem_error=1. Assert reset with 2 reads in flight (READ_LATENCY=3) -> no valid pulses follow and ready=1 after release.

Source files
------------

// File: rtl/mem_subsystem_pkg.sv
// Shared helpers for the pipelined dual-port memory subsystem.
// Latency: n/a (elaboration-time functions and constants only).
// Backpressure: n/a.
// Contents: log2, byte/word address geometry, and clamps that keep the
// read latency (1..4) and wait-state count (0..7) inside their legal ranges.
package mem_subsystem_pkg;

  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_WAIT_STATES  = 7;
  localparam int WAIT_CNT_BITS    = 3;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int num_bytes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int word_addr_bits(input int data_width, input int mem_address_bits);
    return mem_address_bits - log2(num_bytes(data_width));
  endfunction

  function automatic int clamp_latency(input int read_latency);
    if (read_latency < 1) return 1;
    if (read_latency > MAX_READ_LATENCY) return MAX_READ_LATENCY;
    return read_latency;
  endfunction

  function automatic int clamp_wait(input int wait_states);
    if (wait_states < 0) return 0;
    if (wait_states > MAX_WAIT_STATES) return MAX_WAIT_STATES;
    return wait_states;
  endfunction

endpackage

// File: rtl/mem_port_pipeline.sv
// Per-port control: wait-state counter, ready, range check, valid/address/error pipe.
// Latency: accepted read shows valid READ_LATENCY cycles later as a 1-cycle pulse.
// Backpressure: ready drops for WAIT_STATES cycles after every accept; held requests wait.
// Ports: req/rd/address_in from the requester; ready/valid/address_out/error to it;
// in_range and stage_load go to the top level to steer the data-path registers.
module mem_port_pipeline
  import mem_subsystem_pkg::*;
#(
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 12,
  parameter int READ_LATENCY     = 1,
  parameter int WAIT_STATES      = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    rd,
  input  logic [ADDRESS_BITS-1:0] address_in,
  output logic                    ready,
  output logic                    in_range,
  output logic [READ_LATENCY-1:0] stage_load,
  output logic                    valid,
  output logic [ADDRESS_BITS-1:0] address_out,
  output logic                    error
);

  logic [WAIT_CNT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic [READ_LATENCY-1:0]  vld_q, vld_d;
  logic [READ_LATENCY-1:0]  err_q, err_d;
  logic [ADDRESS_BITS-1:0]  addr_q [READ_LATENCY];
  logic [ADDRESS_BITS-1:0]  addr_d [READ_LATENCY];
  logic                     accept;

  assign in_range = ((address_in >> MEM_ADDRESS_BITS) == '0);
  assign ready    = (wait_cnt_q == '0);
  assign accept   = req & ready;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (accept) begin
      wait_cnt_d = WAIT_CNT_BITS'(WAIT_STATES);
    end else if (wait_cnt_q != '0) begin
      wait_cnt_d = wait_cnt_q - WAIT_CNT_BITS'(1);
    end
  end

  // Address/error stages only move when a valid entry moves into them, so the
  // last stage keeps describing the most recently returned read.
  always_comb begin
    vld_d  = vld_q;
    err_d  = err_q;
    addr_d = addr_q;
    vld_d[0] = accept & rd;
    if (accept & rd) begin
      addr_d[0] = address_in;
      err_d[0]  = ~in_range;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        addr_d[k] = addr_q[k-1];
        err_d[k]  = err_q[k-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      vld_q      <= '0;
      err_q      <= '0;
      for (int k = 0; k < READ_LATENCY; k++) addr_q[k] <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
    end
  end

  assign stage_load  = vld_d;
  assign valid       = vld_q[READ_LATENCY-1];
  assign address_out = addr_q[READ_LATENCY-1];
  assign error       = err_q[READ_LATENCY-1] & vld_q[READ_LATENCY-1];

endmodule

// File: rtl/pipelined_dual_port_memory_subsystem.sv
// Fetch (read-only) + data (read/write, byte enables) ports over one shared word array.
// Latency: READ_LATENCY cycles accept-to-valid on both ports, in order, one per cycle.
// Backpressure: per-port ready low for WAIT_STATES cycles after each accept.
// Ports: i_mem_* fetch request/response, d_mem_* data request/response; *_error flags an
// out-of-range access in its valid cycle. Array is read-first; memory survives reset.
module pipelined_dual_port_memory_subsystem
  import mem_subsystem_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 12,
  parameter int READ_LATENCY     = 1,
  parameter int WAIT_STATES      = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_mem_read,
  input  logic [ADDRESS_BITS-1:0] i_mem_address_in,
  output logic [DATA_WIDTH-1:0]   i_mem_data_out,
  output logic [ADDRESS_BITS-1:0] i_mem_address_out,
  output logic                    i_mem_valid,
  output logic                    i_mem_ready,
  output logic                    i_mem_error,
  input  logic                    d_mem_read,
  input  logic                    d_mem_write,
  input  logic [DATA_WIDTH/8-1:0] d_mem_byte_en,
  input  logic [ADDRESS_BITS-1:0] d_mem_address_in,
  input  logic [DATA_WIDTH-1:0]   d_mem_data_in,
  output logic [DATA_WIDTH-1:0]   d_mem_data_out,
  output logic [ADDRESS_BITS-1:0] d_mem_address_out,
  output logic                    d_mem_valid,
  output logic                    d_mem_ready,
  output logic                    d_mem_error
);

  localparam int RL             = clamp_latency(READ_LATENCY);
  localparam int WS             = clamp_wait(WAIT_STATES);
  localparam int NUM_BYTES      = num_bytes(DATA_WIDTH);
  localparam int OFFSET_BITS    = log2(NUM_BYTES);
  localparam int WORD_ADDR_BITS = word_addr_bits(DATA_WIDTH, MEM_ADDRESS_BITS);
  localparam int DEPTH          = 1 << WORD_ADDR_BITS;

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  logic [WORD_ADDR_BITS-1:0] i_idx, d_idx;
  logic                      i_in_range, d_in_range, d_wr_en;
  logic [RL-1:0]             i_load, d_load;
  logic [DATA_WIDTH-1:0]     i_dat_q [RL];
  logic [DATA_WIDTH-1:0]     i_dat_d [RL];
  logic [DATA_WIDTH-1:0]     d_dat_q [RL];
  logic [DATA_WIDTH-1:0]     d_dat_d [RL];

  // Byte-offset bits are dropped: accesses are whole words.
  assign i_idx = i_mem_address_in[MEM_ADDRESS_BITS-1:OFFSET_BITS];
  assign d_idx = d_mem_address_in[MEM_ADDRESS_BITS-1:OFFSET_BITS];

  mem_port_pipeline #(
    .ADDRESS_BITS(ADDRESS_BITS), .MEM_ADDRESS_BITS(MEM_ADDRESS_BITS),
    .READ_LATENCY(RL), .WAIT_STATES(WS)
  ) u_i_port (
    .clock(clock), .reset(reset),
    .req(i_mem_read), .rd(i_mem_read), .address_in(i_mem_address_in),
    .ready(i_mem_ready), .in_range(i_in_range), .stage_load(i_load),
    .valid(i_mem_valid), .address_out(i_mem_address_out), .error(i_mem_error)
  );

  mem_port_pipeline #(
    .ADDRESS_BITS(ADDRESS_BITS), .MEM_ADDRESS_BITS(MEM_ADDRESS_BITS),
    .READ_LATENCY(RL), .WAIT_STATES(WS)
  ) u_d_port (
    .clock(clock), .reset(reset),
    .req(d_mem_read | d_mem_write), .rd(d_mem_read), .address_in(d_mem_address_in),
    .ready(d_mem_ready), .in_range(d_in_range), .stage_load(d_load),
    .valid(d_mem_valid), .address_out(d_mem_address_out), .error(d_mem_error)
  );

  // Out-of-range writes are dropped rather than aliased onto the low words.
  assign d_wr_en = d_mem_write & d_mem_ready & d_in_range;

  // The array is sampled before this edge's write lands, which makes a read
  // colliding with a write (either port) return the old word.
  always_comb begin
    i_dat_d = i_dat_q;
    d_dat_d = d_dat_q;
    if (i_load[0]) i_dat_d[0] = i_in_range ? mem_q[i_idx] : '0;
    if (d_load[0]) d_dat_d[0] = d_in_range ? mem_q[d_idx] : '0;
    for (int k = 1; k < RL; k++) begin
      if (i_load[k]) i_dat_d[k] = i_dat_q[k-1];
      if (d_load[k]) d_dat_d[k] = d_dat_q[k-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < RL; k++) begin
        i_dat_q[k] <= '0;
        d_dat_q[k] <= '0;
      end
    end else begin
      i_dat_q <= i_dat_d;
      d_dat_q <= d_dat_d;
    end
  end

  // No reset on the array: contents are preserved across reset.
  always_ff @(posedge clock) begin
    if (d_wr_en) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (d_mem_byte_en[k]) mem_q[d_idx][k*8 +: 8] <= d_mem_data_in[k*8 +: 8];
      end
    end
  end

  assign i_mem_data_out = i_dat_q[RL-1];
  assign d_mem_data_out = d_dat_q[RL-1];

endmodule

// File: tb/tb_pipelined_dual_port_memory_subsystem.sv
// Bench for pipelined_dual_port_memory_subsystem: three instances share the inputs.
// Instance 0: latency 1, no wait states. Instance 1: latency 3. Instance 2: 2 wait states.
module tb_pipelined_dual_port_memory_subsystem;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_read, d_read, d_write;
  logic [31:0] i_addr, d_addr, d_wdat;
  logic [3:0]  d_be;

  logic [31:0] i_dat [3];
  logic [31:0] i_ao  [3];
  logic [31:0] d_dat [3];
  logic [31:0] d_ao  [3];
  logic [2:0]  i_vld, i_rdy, i_err, d_vld, d_rdy, d_err;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipelined_dual_port_memory_subsystem #(
      .DATA_WIDTH(32), .ADDRESS_BITS(32), .MEM_ADDRESS_BITS(12),
      .READ_LATENCY((g == 1) ? 3 : 1), .WAIT_STATES((g == 2) ? 2 : 0)
    ) u_dut (
      .clock(clock), .reset(reset),
      .i_mem_read(i_read), .i_mem_address_in(i_addr),
      .i_mem_data_out(i_dat[g]), .i_mem_address_out(i_ao[g]),
      .i_mem_valid(i_vld[g]), .i_mem_ready(i_rdy[g]), .i_mem_error(i_err[g]),
      .d_mem_read(d_read), .d_mem_write(d_write), .d_mem_byte_en(d_be),
      .d_mem_address_in(d_addr), .d_mem_data_in(d_wdat),
      .d_mem_data_out(d_dat[g]), .d_mem_address_out(d_ao[g]),
      .d_mem_valid(d_vld[g]), .d_mem_ready(d_rdy[g]), .d_mem_error(d_err[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_be = '0; d_addr = '0; d_wdat = '0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] init_vals [3];
  logic [31:0] model [16];

  function automatic logic [31:0] rnd_addr(input int k, input bit oor);
    logic [31:0] a;
    a = 32'h100 + 32'(4 * k) + 32'($urandom_range(0, 3));
    if (oor) a = a | (32'h1 << $urandom_range(12, 31));
    return a;
  endfunction

  // Hard stop if something upstream ever stalls the schedule.
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_i, last_d, e_idat, e_ddat, ia, da, wd;
    logic        ir, dr, dw, ioor, door, rdy_seen;
    logic [3:0]  be;
    int          ik, dk, op, idx, npulse;
    logic [2:0]  exp_rdy_ws [8];
    logic        exp_vld_ws [8];

    init_vals[0] = 32'h1111_0000;
    init_vals[1] = 32'h2222_0004;
    init_vals[2] = 32'h3333_0008;

    //            rd    wr    be    addr          wdat          exp_dat       err
    tbl[0]  = '{1'b0, 1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'hF, 32'h20,       32'h11223344, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'h1, 32'h20,       32'h000000AA, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 32'h20,       32'h0,        32'h112233AA, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 32'h20,       32'hFFFFFFFF, 32'h0,        1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 32'h23,       32'h0,        32'h112233AA, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'h8, 32'h20,       32'h55000000, 32'h0,        1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'h0, 32'h20,       32'h0,        32'h552233AA, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'hF, 32'h1000,     32'h12345678, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 32'h0,        32'h0,        32'h11110000, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 4'h0, 32'h1000,     32'h0,        32'h0,        1'b1};
    tbl[12] = '{1'b1, 1'b0, 4'h0, 32'h80000004, 32'h0,        32'h0,        1'b1};
    tbl[13] = '{1'b0, 1'b1, 4'hF, 32'h30,       32'h1,        32'h0,        1'b0};
    tbl[14] = '{1'b1, 1'b1, 4'hF, 32'h30,       32'h2,        32'h1,        1'b0};
    tbl[15] = '{1'b1, 1'b0, 4'h0, 32'h30,       32'h0,        32'h2,        1'b0};

    // ---- reset state ----
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk1("rst_i_vld", i_vld[g], 1'b0);
      chk1("rst_d_vld", d_vld[g], 1'b0);
      chk1("rst_i_err", i_err[g], 1'b0);
      chk1("rst_d_err", d_err[g], 1'b0);
      chk("rst_i_dat", i_dat[g], 32'h0);
      chk("rst_d_dat", d_dat[g], 32'h0);
      chk("rst_i_ao", i_ao[g], 32'h0);
      chk("rst_d_ao", d_ao[g], 32'h0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk1("post_rst_i_rdy", i_rdy[g], 1'b1);
      chk1("post_rst_d_rdy", d_rdy[g], 1'b1);
    end

    // ---- seed words 0x0/0x4/0x8 ----
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      d_write = 1'b1; d_be = 4'hF; d_addr = 32'(4 * n); d_wdat = init_vals[n];
    end
    @(negedge clock);
    idle_inputs();

    // ---- directed table on instance 0 ----
    for (int t = 0; t < 16; t++) begin
      @(negedge clock);
      idle_inputs();
      d_read = tbl[t].rd; d_write = tbl[t].wr; d_be = tbl[t].be;
      d_addr = tbl[t].addr; d_wdat = tbl[t].wdat;
      @(posedge clock);
      #1;
      chk1($sformatf("tbl%0d_vld", t), d_vld[0], tbl[t].rd);
      if (tbl[t].rd) begin
        chk($sformatf("tbl%0d_dat", t), d_dat[0], tbl[t].exp_dat);
        chk($sformatf("tbl%0d_ao", t), d_ao[0], tbl[t].addr);
        chk1($sformatf("tbl%0d_err", t), d_err[0], tbl[t].exp_err);
      end
    end

    // ---- fetch/data collision on 0x34 ----
    @(negedge clock);
    idle_inputs();
    d_write = 1'b1; d_be = 4'hF; d_addr = 32'h34; d_wdat = 32'h1;
    @(negedge clock);
    i_read = 1'b1; i_addr = 32'h34; d_wdat = 32'h2;
    @(posedge clock);
    #1;
    chk1("col_old_vld", i_vld[0], 1'b1);
    chk("col_old_dat", i_dat[0], 32'h1);
    chk1("col_old_dvld", d_vld[0], 1'b0);
    @(negedge clock);
    d_write = 1'b0; d_read = 1'b1; d_addr = 32'h34;
    @(posedge clock);
    #1;
    chk("col_new_i_dat", i_dat[0], 32'h2);
    chk("col_new_d_dat", d_dat[0], 32'h2);
    chk1("col_new_both_vld", i_vld[0] & d_vld[0], 1'b1);
    chk("col_i_ao", i_ao[0], 32'h34);
    chk("col_d_ao", d_ao[0], 32'h34);
    last_i = 32'h2;
    last_d = 32'h2;

    // ---- randomized traffic on instance 0 against an array model ----
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      idle_inputs();
      d_write = 1'b1; d_be = 4'hF; d_addr = 32'h100 + 32'(4 * k);
      d_wdat = $urandom;
      model[k] = d_wdat;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      ir   = 1'($urandom_range(0, 1));
      ik   = int'($urandom_range(0, 15));
      ioor = ($urandom_range(0, 7) == 0);
      ia   = rnd_addr(ik, ioor);
      op   = int'($urandom_range(0, 3));
      dr   = op[0];
      dw   = op[1];
      dk   = int'($urandom_range(0, 15));
      door = ($urandom_range(0, 7) == 0);
      da   = rnd_addr(dk, door);
      be   = 4'($urandom_range(0, 15));
      wd   = $urandom;
      // Reads see the word as it was before this cycle's write.
      e_idat = ioor ? 32'h0 : model[ik];
      e_ddat = door ? 32'h0 : model[dk];
      if (dw && !door) begin
        for (int b = 0; b < 4; b++) if (be[b]) model[dk][8*b +: 8] = wd[8*b +: 8];
      end
      i_read = ir; i_addr = ia;
      d_read = dr; d_write = dw; d_be = be; d_addr = da; d_wdat = wd;
      @(posedge clock);
      #1;
      chk1("rnd_i_vld", i_vld[0], ir);
      if (ir) begin
        chk("rnd_i_dat", i_dat[0], e_idat);
        chk("rnd_i_ao", i_ao[0], ia);
        chk1("rnd_i_err", i_err[0], ioor);
        last_i = e_idat;
      end else begin
        chk("rnd_i_hold", i_dat[0], last_i);
      end
      chk1("rnd_d_vld", d_vld[0], dr);
      if (dr) begin
        chk("rnd_d_dat", d_dat[0], e_ddat);
        chk("rnd_d_ao", d_ao[0], da);
        chk1("rnd_d_err", d_err[0], door);
        last_d = e_ddat;
      end else begin
        chk("rnd_d_hold", d_dat[0], last_d);
      end
    end
    @(negedge clock);
    idle_inputs();
    repeat (6) @(posedge clock);

    // ---- latency 3: fetches of 0x0, 0x4, 0x8 on consecutive cycles ----
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      i_read = (c < 3);
      i_addr = 32'(4 * c);
      @(posedge clock);
      #1;
      chk1($sformatf("lat3_vld_c%0d", c), i_vld[1], (c >= 2 && c <= 4));
      if (c >= 2 && c <= 4) begin
        chk("lat3_ao", i_ao[1], 32'(4 * (c - 2)));
        chk("lat3_dat", i_dat[1], init_vals[c-2]);
        chk1("lat3_err", i_err[1], 1'b0);
      end
    end

    // ---- reset with two fetches in flight ----
    @(negedge clock);
    i_read = 1'b1; i_addr = 32'h0;
    @(negedge clock);
    i_addr = 32'h4;
    @(negedge clock);
    i_read = 1'b0;
    reset = 1'b0;
    #1;
    chk1("flush_async_vld", i_vld[1], 1'b0);
    chk("flush_async_dat", i_dat[1], 32'h0);
    chk("flush_async_ao", i_ao[1], 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      #1;
      chk1("flush_no_vld", i_vld[1], 1'b0);
      chk1("flush_i_rdy", i_rdy[1], 1'b1);
    end
    // Array contents survive reset.
    @(negedge clock);
    i_read = 1'b1; i_addr = 32'h8;
    @(posedge clock);
    #1;
    chk1("keep_vld_c0", i_vld[1], 1'b0);
    @(negedge clock);
    i_read = 1'b0;
    @(posedge clock);
    #1;
    chk1("keep_vld_c1", i_vld[1], 1'b0);
    @(posedge clock);
    #1;
    chk1("keep_vld_c2", i_vld[1], 1'b1);
    chk("keep_dat", i_dat[1], init_vals[2]);
    chk("keep_ao", i_ao[1], 32'h8);
    repeat (4) @(posedge clock);

    // ---- two wait states: held reads of 0x40 then 0x44 ----
    exp_rdy_ws = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    exp_vld_ws = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    idx = 0;
    npulse = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      idle_inputs();
      if (idx < 2) begin
        d_read = 1'b1;
        d_addr = (idx == 0) ? 32'h40 : 32'h44;
      end
      rdy_seen = d_rdy[2];
      @(posedge clock);
      #1;
      if (d_read && rdy_seen) idx++;
      chk1($sformatf("ws_rdy_c%0d", c), d_rdy[2], exp_rdy_ws[c][0]);
      chk1($sformatf("ws_vld_c%0d", c), d_vld[2], exp_vld_ws[c]);
      if (exp_vld_ws[c]) chk("ws_ao", d_ao[2], (c == 0) ? 32'h40 : 32'h44);
      if (d_vld[2]) npulse++;
    end
    chk("ws_pulses", 32'(npulse), 32'd2);
    chk("ws_accepts", 32'(idx), 32'd2);

    @(negedge clock);
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
